// File: rtl/seq_gen_lrr_if.sv
// Stream and control bundle for the linear-recurrence sequence generator.
interface seq_gen_lrr_if #(
    parameter int DataBus = 32,
    parameter int Order   = 4,
    parameter int CntW    = 16
) ();
    logic                 start_i;
    logic [Order-1:0]     taps_i;
    logic [CntW-1:0]      term_limit_i;
    logic                 ready_i;
    logic                 valid_o;
    logic [DataBus-1:0]   seq_o;
    logic                 done_o;
    logic                 overflow_o;
    logic [CntW-1:0]      term_cnt_o;

    modport master (
        output start_i, taps_i, term_limit_i, ready_i,
        input  valid_o, seq_o, done_o, overflow_o, term_cnt_o
    );

    modport slave (
        input  start_i, taps_i, term_limit_i, ready_i,
        output valid_o, seq_o, done_o, overflow_o, term_cnt_o
    );
endinterface

// File: rtl/seq_gen_lrr.sv
// Linear-recurrence generator: each term is the sum of the tapped previous terms,
// emitted on a valid/ready stream with a per-run term limit and overflow handling.
//
//  state  | meaning
//  S_IDLE | after reset, no run configured, outputs quiet
//  S_RUN  | presenting h[0]; advances on every accepted term
//  S_DONE | term limit reached, counters frozen until the next start
module seq_gen_lrr #(
    parameter int DataBus  = 32,
    parameter int Order    = 4,
    parameter int CntW     = 16,
    parameter int Saturate = 0
) (
    input  logic          clk,
    input  logic          reset,
    seq_gen_lrr_if.slave  bus
);
    localparam int SumW = DataBus + $clog2(Order) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DataBus-1:0]   r_hist [Order];
    logic [Order-1:0]     r_taps;
    logic [CntW-1:0]      r_limit;
    logic [CntW-1:0]      r_cnt;
    logic                 r_ovf;

    logic [SumW-1:0]      w_sum;
    logic                 w_over;
    logic [DataBus-1:0]   w_next;
    logic                 w_accept;
    logic [CntW-1:0]      w_cnt_inc;
    logic                 w_terminal;
    logic                 w_valid;
    logic                 w_done;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < Order; k++) begin
            if (r_taps[k]) w_sum = w_sum + SumW'(r_hist[k]);
        end
    end

    assign w_over     = |w_sum[SumW-1:DataBus];
    assign w_next     = (w_over && (Saturate != 0)) ? '1 : w_sum[DataBus-1:0];
    assign w_accept   = (r_state == S_RUN) && bus.ready_i;
    assign w_cnt_inc  = r_cnt + CntW'(1);
    assign w_terminal = w_accept && (r_limit != '0) && (w_cnt_inc == r_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_RUN:   w_valid = 1'b1;
            S_DONE:  w_done  = 1'b1;
            default: ;
        endcase
        // A restart overrides whatever the current term was doing.
        if (bus.start_i)      w_state_nxt = S_RUN;
        else if (w_terminal)  w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < Order; k++) r_hist[k] <= '0;
            r_taps  <= '0;
            r_limit <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.start_i) begin
            r_hist[0] <= DataBus'(1);
            for (int k = 1; k < Order; k++) r_hist[k] <= '0;
            r_taps  <= bus.taps_i;
            r_limit <= bus.term_limit_i;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_inc;
            // The terminal term leaves the history untouched, so no new term is formed.
            if (!w_terminal) begin
                for (int k = 1; k < Order; k++) r_hist[k] <= r_hist[k-1];
                r_hist[0] <= w_next;
                if (w_over) r_ovf <= 1'b1;
            end
        end
    end

    assign bus.valid_o    = w_valid;
    assign bus.seq_o      = w_valid ? r_hist[0] : '0;
    assign bus.done_o     = w_done;
    assign bus.overflow_o = r_ovf;
    assign bus.term_cnt_o = r_cnt;
endmodule

// File: tb/tb_seq_gen_lrr.sv
// Bench for seq_gen_lrr: three instances (32-bit wrap, 8-bit wrap, 8-bit saturate)
// share one stimulus stream and are checked each cycle against a term-list model.
module tb_seq_gen_lrr;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  taps;
    logic [15:0] limit;
    logic        ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_gen_lrr_if #(.DataBus(32), .Order(4), .CntW(16)) if0 ();
    seq_gen_lrr_if #(.DataBus(8),  .Order(4), .CntW(4))  if1 ();
    seq_gen_lrr_if #(.DataBus(8),  .Order(4), .CntW(4))  if2 ();

    assign if0.start_i = start;  assign if0.taps_i = taps;
    assign if0.term_limit_i = limit;        assign if0.ready_i = ready;
    assign if1.start_i = start;  assign if1.taps_i = taps;
    assign if1.term_limit_i = limit[3:0];   assign if1.ready_i = ready;
    assign if2.start_i = start;  assign if2.taps_i = taps;
    assign if2.term_limit_i = limit[3:0];   assign if2.ready_i = ready;

    seq_gen_lrr #(.DataBus(32), .Order(4), .CntW(16), .Saturate(0)) u_d32 (.clk(clk), .reset(reset), .bus(if0));
    seq_gen_lrr #(.DataBus(8),  .Order(4), .CntW(4),  .Saturate(0)) u_d8w (.clk(clk), .reset(reset), .bus(if1));
    seq_gen_lrr #(.DataBus(8),  .Order(4), .CntW(4),  .Saturate(1)) u_d8s (.clk(clk), .reset(reset), .bus(if2));

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: run mode (0 idle, 1 run, 2 done) and the list of recent terms, newest first.
    int     m_w[3]   = '{32, 8, 8};
    int     m_sat[3] = '{0, 0, 1};
    int     m_cw[3]  = '{16, 4, 4};
    int     m_mode[3];
    longint m_terms[3][4];
    longint m_cnt[3];
    int     m_ovf[3];
    int     m_taps[3];
    longint m_lim[3];

    initial begin
        longint mask, cmask, sum, nc;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            for (int k = 0; k < 4; k++) m_terms[i][k] = 0;
        end
        forever begin
            @(posedge clk or posedge reset);
            for (int i = 0; i < 3; i++) begin
                mask  = (64'd1 << m_w[i]) - 1;
                cmask = (64'd1 << m_cw[i]) - 1;
                if (reset) begin
                    m_mode[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                    for (int k = 0; k < 4; k++) m_terms[i][k] = 0;
                end else if (start) begin
                    m_mode[i] = 1; m_cnt[i] = 0; m_ovf[i] = 0;
                    m_taps[i] = int'(taps);
                    m_lim[i]  = longint'(limit) & cmask;
                    m_terms[i][0] = 1;
                    for (int k = 1; k < 4; k++) m_terms[i][k] = 0;
                end else if (m_mode[i] == 1 && ready) begin
                    nc = (m_cnt[i] + 1) & cmask;
                    m_cnt[i] = nc;
                    if (m_lim[i] != 0 && nc == m_lim[i]) begin
                        m_mode[i] = 2;
                    end else begin
                        sum = 0;
                        for (int k = 0; k < 4; k++)
                            if (m_taps[i][k]) sum += m_terms[i][k];
                        if (sum > mask) begin
                            m_ovf[i] = 1;
                            sum = (m_sat[i] != 0) ? mask : (sum & mask);
                        end
                        for (int k = 3; k > 0; k--) m_terms[i][k] = m_terms[i][k-1];
                        m_terms[i][0] = sum;
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] av, as, ad, ao, ac;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < 3; i++) begin
                    case (i)
                        0: begin av = 64'(if0.valid_o); as = 64'(if0.seq_o); ad = 64'(if0.done_o);
                                 ao = 64'(if0.overflow_o); ac = 64'(if0.term_cnt_o); end
                        1: begin av = 64'(if1.valid_o); as = 64'(if1.seq_o); ad = 64'(if1.done_o);
                                 ao = 64'(if1.overflow_o); ac = 64'(if1.term_cnt_o); end
                        default: begin av = 64'(if2.valid_o); as = 64'(if2.seq_o); ad = 64'(if2.done_o);
                                 ao = 64'(if2.overflow_o); ac = 64'(if2.term_cnt_o); end
                    endcase
                    check($sformatf("model d%0d valid", i), av, 64'(m_mode[i] == 1));
                    check($sformatf("model d%0d seq", i),   as, (m_mode[i] == 1) ? m_terms[i][0] : 64'd0);
                    check($sformatf("model d%0d done", i),  ad, 64'(m_mode[i] == 2));
                    check($sformatf("model d%0d ovf", i),   ao, 64'(m_ovf[i]));
                    check($sformatf("model d%0d cnt", i),   ac, m_cnt[i]);
                end
            end
        end
    end

    task automatic start_run(input logic [3:0] t, input logic [15:0] l);
        @(negedge clk);
        start = 1'b1; taps = t; limit = l;
        @(negedge clk);
        start = 1'b0; taps = 4'($urandom); limit = 16'($urandom);
    endtask

    int e1[6]   = '{1, 1, 2, 3, 5, 8};
    int e2a[6]  = '{1, 1, 2, 4, 7, 13};
    int e2b[8]  = '{1, 0, 1, 1, 1, 2, 2, 3};
    int e4w[15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    int e4s[15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 255, 255};

    initial begin
        reset = 1'b1; start = 1'b0; taps = '0; limit = '0; ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset valid", 64'(if0.valid_o), 0);
        check("reset seq",   64'(if0.seq_o), 0);
        check("reset done",  64'(if0.done_o), 0);
        check("reset cnt",   64'(if0.term_cnt_o), 0);

        ready = 1'b1;
        start_run(4'b0011, 16'd6);
        for (int i = 0; i < 6; i++) begin
            check("fib seq", 64'(if0.seq_o), 64'(e1[i]));
            @(negedge clk);
        end
        check("fib done",  64'(if0.done_o), 1);
        check("fib valid", 64'(if0.valid_o), 0);
        check("fib cnt",   64'(if0.term_cnt_o), 6);
        @(negedge clk);
        check("fib hold cnt", 64'(if0.term_cnt_o), 6);

        start_run(4'b0111, 16'd6);
        for (int i = 0; i < 6; i++) begin
            check("trib seq", 64'(if0.seq_o), 64'(e2a[i]));
            @(negedge clk);
        end
        start_run(4'b0110, 16'd8);
        for (int i = 0; i < 8; i++) begin
            check("pad seq", 64'(if0.seq_o), 64'(e2b[i]));
            @(negedge clk);
        end
        check("pad done", 64'(if0.done_o), 1);

        start_run(4'b0011, 16'd0);
        for (int i = 0; i < 15; i++) begin
            check("wrap8 seq", 64'(if1.seq_o), 64'(e4w[i]));
            check("sat8 seq",  64'(if2.seq_o), 64'(e4s[i]));
            if (i == 12) check("wrap8 ovf before", 64'(if1.overflow_o), 0);
            if (i == 13) begin
                check("wrap8 ovf after", 64'(if1.overflow_o), 1);
                check("sat8 ovf after",  64'(if2.overflow_o), 1);
            end
            @(negedge clk);
        end

        start_run(4'b0011, 16'd0);
        check("restart ovf clr", 64'(if1.overflow_o), 0);
        check("restart seq",     64'(if0.seq_o), 1);
        repeat (4) @(negedge clk);
        check("pre-abort seq", 64'(if0.seq_o), 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort seq",   64'(if0.seq_o), 1);
        check("abort cnt",   64'(if0.term_cnt_o), 0);
        check("abort valid", 64'(if0.valid_o), 1);

        for (int r = 0; r < 6; r++) begin
            taps  = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            limit = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            start = 1'b1;
            @(negedge clk);
            for (int c = 0; c < 150; c++) begin
                ready = ($urandom_range(0, 3) != 0);
                taps  = 4'($urandom);
                limit = 16'($urandom_range(0, 20));
                start = ($urandom_range(0, 59) == 0);
                @(negedge clk);
            end
        end

        ready = 1'b1;
        start_run(4'b1111, 16'd0);
        repeat (20) @(negedge clk);
        check("pre-reset ovf", 64'(if1.overflow_o), 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async valid", 64'(if0.valid_o), 0);
        check("async seq",   64'(if0.seq_o), 0);
        check("async cnt",   64'(if0.term_cnt_o), 0);
        check("async ovf",   64'(if1.overflow_o), 0);
        check("async cnt8",  64'(if1.term_cnt_o), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle valid", 64'(if0.valid_o), 0);
        check("idle done",  64'(if0.done_o), 0);
        start_run(4'b0011, 16'd3);
        check("post-reset seq", 64'(if0.seq_o), 1);
        repeat (4) @(negedge clk);
        check("post-reset done", 64'(if0.done_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
